wb_burst_master: RTL and testbench
==================================

// Module: wb_burst_master
// PURPOSE
//  Synthesizable Wishbone B4 burst master sitting directly upstream of sdrc_top's wb_* slave port.
//  Turns simple commands (addr, beat count, dir) into one Wishbone cycle with CTI-tagged bursts.
//  Streams write data in and read data out, so app/traffic logic never drives wb_* directly.
// PARAMETERS
//  AW          32    wb_addr_i width (byte address)
//  DW          32    wb_dat width; SEL width = DW/8, address step = DW/8
//  LEN_W       8     cmd_len width; legal length 1..2**LEN_W-1 beats
//  TIMEOUT_CYC 1024  max cycles waiting one wb_ack_o (WB_MASTER_TIMEOUT_EN only)
// PORTS
//  sys_clk     in   1      clock (same as sdrc_top wb_clk_i)
//  RESETN      in   1      synchronous active-low reset
//  cmd_valid   in   1      command request
//  cmd_ready   out  1      high only in IDLE; command taken on cmd_valid&&cmd_ready
//  cmd_we      in   1      1=write, 0=read
//  cmd_addr    in   AW     start byte address, DW/8-aligned
//  cmd_len     in   LEN_W  beat count; 0 treated as 1
//  wr_valid    in   1      write-data beat available
//  wr_ready    out  1      write beat consumed (== wb_ack_o during write)
//  wr_data     in   DW     write-data beat
//  rd_valid    out  1      one-cycle read beat strobe, no backpressure
//  rd_data     out  DW     read beat (registered wb_dat_o)
//  done        out  1      one-cycle pulse after final ack
//  timeout     out  1      sticky error flag (0 when macro off)
//  wb_cyc_i/wb_stb_i/wb_we_i out 1; wb_addr_i out AW; wb_dat_i out DW; wb_sel_i out DW/8;
//  wb_cti_i out 3; wb_ack_o in 1; wb_dat_o in DW  -- named as sdrc_top slave pins
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, cmd_ready=0 in reset cycle, 1 the cycle after.
//  FSM: IDLE -> WR|RD on accept (addr/len/we registered) -> IDLE after last ack (done=1).
//  Latency: accept at cycle N -> wb_cyc_i=1 at N+1; read data at rd_valid one cycle after ack.
//  wb_cyc_i held high for the whole burst; wb_sel_i all ones; wb_we_i=cmd_we for the burst.
//  WR: wb_stb_i = wr_valid (gaps allowed, cyc stays high); wb_dat_i=wr_data; wr_ready=wb_ack_o.
//  RD: wb_stb_i held high until last ack.
//  On every ack: addr += DW/8 (wraps modulo 2**AW), remaining beats -= 1.
//  CTI: 3'b010 on every beat except last; last beat (incl. len 1) 3'b111.
//  BTE (not a port): linear.
//  Ack with stb low is ignored. Next command may be accepted the cycle after done.
//  cmd_valid while busy: cmd_ready=0, no effect.
//  RESETN low mid-burst: cyc/stb drop next edge, counters cleared, no done pulse.
// CONFIGURATION
//  WB_MASTER_TIMEOUT_EN defined:
//   - counter runs while stb&&!ack and clears on ack;
//   - at TIMEOUT_CYC: cyc/stb drop, timeout=1 (sticky to reset), FSM -> IDLE, done NOT pulsed.
//  Undefined: no counter, timeout tied 0, master waits indefinitely.
// STRUCTURE
//  sdrctrl_package: wbm_state_e {IDLE,WR,RD}; CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
//  Sub-module wbm_ack_watchdog (counter + expiry) instantiated only under WB_MASTER_TIMEOUT_EN.
// TESTING
//  1 write addr 0x100, len 4, data A0..A3 -> 4 acks, addrs 100/104/108/10C, CTI 2,2,2,7, done once.
//  2 read same, len 4 -> rd_valid x4, rd_data A0..A3 in order, cyc low the cycle after done.
//  3 write len 1 (and len 0) to 0x40 -> single beat CTI=3'b111, readback equals written.
//  4 write len 8, wr_valid low 3 cycles after beat 2 -> stb low, cyc high, data/addr intact.
//  5 RESETN low 1 cycle during beat 3 of read len 8 -> cyc/stb 0 next cycle, no done, new cmd ok.
//  6 (macro on, TIMEOUT_CYC=16) slave never acks -> cyc drops at cycle 16, timeout=1, done=0.

Source files
------------

// File: rtl/sdrctrl_package.sv
// Shared types and constants for the Wishbone burst master in front of sdrc_top.
package sdrctrl_package;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } wbm_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wbm_ack_watchdog.sv
// Counts cycles spent waiting on a single Wishbone ack; flags expiry.
// Only built when WB_MASTER_TIMEOUT_EN is defined.
`ifdef WB_MASTER_TIMEOUT_EN
module wbm_ack_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + CW'(1);
    end
  end

  // Fires in the last waiting cycle so the bus drops exactly TIMEOUT_CYC cycles in.
  assign expire = run && (count == CW'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/wb_burst_master.sv
// Wishbone B4 incrementing-burst master driving sdrc_top's wb_* slave port.
// Optional per-ack watchdog under WB_MASTER_TIMEOUT_EN.
module wb_burst_master
  import sdrctrl_package::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned LEN_W = 8
`ifdef WB_MASTER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
  input  logic             sys_clk,
  input  logic             RESETN,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [DW-1:0]    wr_data,
  output logic             rd_valid,
  output logic [DW-1:0]    rd_data,
  output logic             done,
  output logic             timeout,
  output logic             wb_cyc_i,
  output logic             wb_stb_i,
  output logic             wb_we_i,
  output logic [AW-1:0]    wb_addr_i,
  output logic [DW-1:0]    wb_dat_i,
  output logic [DW/8-1:0]  wb_sel_i,
  output logic [2:0]       wb_cti_i,
  input  logic             wb_ack_o,
  input  logic [DW-1:0]    wb_dat_o
);

  localparam int unsigned STEP = DW / 8;

  wbm_state_e       state, state_next;
  logic [LEN_W-1:0] rem, rem_next;
  logic             cyc_next, we_next, ready_next, done_next, rd_valid_next, timeout_next;
  logic [AW-1:0]    addr_next;
  logic [DW/8-1:0]  sel_next;
  logic [2:0]       cti_next;
  logic [DW-1:0]    rd_data_next;
  logic             beat, expire;

  // Write strobe follows the data source so gaps simply pause the burst.
  assign wb_stb_i = (state == RD) || ((state == WR) && wr_valid);
  assign wb_dat_i = (state == WR) ? wr_data : '0;
  assign wr_ready = (state == WR) && wr_valid && wb_ack_o;
  assign beat     = wb_stb_i && wb_ack_o;

`ifdef WB_MASTER_TIMEOUT_EN
  wbm_ack_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk   (sys_clk),
    .rst_n (RESETN),
    .run   (wb_stb_i && !wb_ack_o),
    .clear (!wb_cyc_i || wb_ack_o),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!RESETN) begin
      state     <= IDLE;
      rem       <= '0;
      cmd_ready <= 1'b0;
      wb_cyc_i  <= 1'b0;
      wb_we_i   <= 1'b0;
      wb_addr_i <= '0;
      wb_sel_i  <= '0;
      wb_cti_i  <= CTI_CLASSIC;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      rem       <= rem_next;
      cmd_ready <= ready_next;
      wb_cyc_i  <= cyc_next;
      wb_we_i   <= we_next;
      wb_addr_i <= addr_next;
      wb_sel_i  <= sel_next;
      wb_cti_i  <= cti_next;
      done      <= done_next;
      rd_valid  <= rd_valid_next;
      rd_data   <= rd_data_next;
      timeout   <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state;
    rem_next      = rem;
    ready_next    = 1'b0;
    cyc_next      = wb_cyc_i;
    we_next       = wb_we_i;
    addr_next     = wb_addr_i;
    sel_next      = wb_sel_i;
    cti_next      = wb_cti_i;
    done_next     = 1'b0;
    rd_valid_next = 1'b0;
    rd_data_next  = rd_data;
    timeout_next  = timeout;
    case (state)
      IDLE: begin
        ready_next = 1'b1;
        if (cmd_valid && cmd_ready) begin
          state_next = cmd_we ? WR : RD;
          ready_next = 1'b0;
          cyc_next   = 1'b1;
          we_next    = cmd_we;
          addr_next  = cmd_addr;
          sel_next   = '1;
          rem_next   = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
          cti_next   = (cmd_len <= LEN_W'(1)) ? CTI_EOB : CTI_INCR;
        end
      end
      WR, RD: begin
        if (expire) begin
          state_next   = IDLE;
          cyc_next     = 1'b0;
          we_next      = 1'b0;
          sel_next     = '0;
          cti_next     = CTI_CLASSIC;
          rem_next     = '0;
          timeout_next = 1'b1;
        end else if (beat) begin
          addr_next     = wb_addr_i + AW'(STEP);
          rem_next      = rem - LEN_W'(1);
          rd_valid_next = (state == RD);
          rd_data_next  = (state == RD) ? wb_dat_o : rd_data;
          cti_next      = (rem == LEN_W'(2)) ? CTI_EOB : CTI_INCR;
          if (rem == LEN_W'(1)) begin
            state_next = IDLE;
            cyc_next   = 1'b0;
            we_next    = 1'b0;
            sel_next   = '0;
            cti_next   = CTI_CLASSIC;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: random-latency Wishbone slave plus memory reference model.
module tb_wb_burst_master;

  logic        sys_clk = 1'b0;
  logic        RESETN = 1'b0;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0, cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [31:0] wr_data = '0;
  logic        rd_valid, done, timeout;
  logic [31:0] rd_data;
  logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
  logic [31:0] wb_addr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic [2:0]  wb_cti_i;

  wb_burst_master #(
    .AW(32), .DW(32), .LEN_W(8)
`ifdef WB_MASTER_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .sys_clk(sys_clk), .RESETN(RESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .timeout(timeout),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_addr_i(wb_addr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_cti_i(wb_cti_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Slave memory, reference memory and slave state
  logic [31:0] smem [0:1023];
  logic [31:0] rmem [0:1023];
  logic [31:0] wbuf [0:15];
  logic        ack_q = 1'b0, stray_ack = 1'b0, noack = 1'b0;
  logic [31:0] sdat = '0;
  logic        timeout_exp = 1'b0;

  assign wb_ack_o = ack_q | stray_ack;
  assign wb_dat_o = sdat;

  always @(posedge sys_clk) begin
    if (wb_cyc_i && wb_stb_i && ack_q && wb_we_i) smem[wb_addr_i[11:2]] <= wb_dat_i;
    if (wb_cyc_i && wb_stb_i && !ack_q && !noack && ($urandom_range(0, 2) != 0)) begin
      ack_q <= 1'b1;
      sdat  <= smem[wb_addr_i[11:2]];
    end else begin
      ack_q <= 1'b0;
    end
  end

  // Bus/stream monitor, sampled mid-cycle
  typedef struct {
    logic [31:0] addr;
    logic [2:0]  cti;
    logic        we;
    logic [31:0] data;
  } beat_t;

  beat_t       beat_q[$];
  logic [31:0] rd_q[$];
  int          done_cnt = 0, lat_bad = 0;
  logic        cyc_at_done = 1'b0, rdy_at_done = 1'b0, prev_rd_ack = 1'b0;

  always @(negedge sys_clk) begin
    beat_t b;
    if (wb_cyc_i && wb_stb_i && wb_ack_o) begin
      b.addr = wb_addr_i;
      b.cti  = wb_cti_i;
      b.we   = wb_we_i;
      b.data = wb_we_i ? wb_dat_i : wb_dat_o;
      beat_q.push_back(b);
    end
    if (rd_valid === 1'b1) rd_q.push_back(rd_data);
    if (rd_valid !== prev_rd_ack) lat_bad++;
    prev_rd_ack = wb_cyc_i && wb_stb_i && wb_ack_o && !wb_we_i;
    if (done === 1'b1) begin
      done_cnt++;
      cyc_at_done = wb_cyc_i;
      rdy_at_done = cmd_ready;
    end
  end

  // One complete command against the reference memory
  task automatic run_burst(input logic we, input logic [31:0] addr, input logic [7:0] len,
                           input int gap_after, input int gap_cyc, input logic stray,
                           input logic poke);
    int          n;
    bit          got;
    logic [31:0] ea;
    logic [2:0]  ecti;
    n = (len == 8'd0) ? 1 : int'(len);
    @(posedge sys_clk); #1;
    beat_q.delete(); rd_q.delete(); done_cnt = 0; lat_bad = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge sys_clk);
      got = (cmd_ready === 1'b1);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL cmd_accept cmd_ready=%b required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_len = 8'($urandom); cmd_we = ~we;
    ecti = (n == 1) ? 3'b111 : 3'b010;
    checks++;
    if (wb_cyc_i !== 1'b1 || wb_we_i !== we || wb_addr_i !== addr || wb_sel_i !== 4'hF ||
        cmd_ready !== 1'b0 || wb_cti_i !== ecti) begin
      errors++;
      $display("FAIL start cyc=%b we=%b addr=%h sel=%h rdy=%b cti=%b required 1 %b %h f 0 %b",
               wb_cyc_i, wb_we_i, wb_addr_i, wb_sel_i, cmd_ready, wb_cti_i, we, addr, ecti);
    end
    if (poke) begin
      for (int k = 0; k < 3; k++) begin
        cmd_valid = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL busy_ready cmd_ready=%b required 0", cmd_ready);
        end
        @(posedge sys_clk); #1;
      end
      cmd_valid = 1'b0;
    end
    if (we) begin
      for (int i = 0; i < n; i++) begin
        wr_valid = 1'b1; wr_data = wbuf[i];
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
          @(negedge sys_clk);
          got = (wr_ready === 1'b1);
        end
        @(posedge sys_clk); #1;
        if (!got) begin
          checks++; errors++;
          $display("FAIL wr_beat_wait beat=%0d wr_ready=%b required 1", i, wr_ready);
          break;
        end
        if (i == gap_after) begin
          wr_valid = 1'b0; wr_data = $urandom;
          stray_ack = stray;
          for (int g = 0; g < gap_cyc; g++) begin
            @(negedge sys_clk);
            ea = addr + 32'(4 * (i + 1));
            checks++;
            if (wb_stb_i !== 1'b0 || wb_cyc_i !== 1'b1 || wb_addr_i !== ea || wr_ready !== 1'b0) begin
              errors++;
              $display("FAIL gap stb=%b cyc=%b addr=%h wr_ready=%b required 0 1 %h 0",
                       wb_stb_i, wb_cyc_i, wb_addr_i, wr_ready, ea);
            end
            @(posedge sys_clk); #1;
            stray_ack = 1'b0;
          end
        end
      end
      wr_valid = 1'b0;
    end
    got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge sys_clk);
      got = (done === 1'b1);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_wait done=%b required 1", done);
      return;
    end
    checks++;
    if (wb_cyc_i !== 1'b0 || cmd_ready !== 1'b0 || timeout !== timeout_exp) begin
      errors++;
      $display("FAIL at_done cyc=%b cmd_ready=%b timeout=%b required 0 0 %b",
               wb_cyc_i, cmd_ready, timeout, timeout_exp);
    end
    @(negedge sys_clk);
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || wb_cyc_i !== 1'b0 || wb_stb_i !== 1'b0) begin
      errors++;
      $display("FAIL after_done done=%b cmd_ready=%b cyc=%b stb=%b required 0 1 0 0",
               done, cmd_ready, wb_cyc_i, wb_stb_i);
    end
    @(negedge sys_clk);
    checks++;
    if (done_cnt != 1 || beat_q.size() != n) begin
      errors++;
      $display("FAIL counts done=%0d beats=%0d required 1 %0d", done_cnt, beat_q.size(), n);
    end
    for (int i = 0; i < n && i < beat_q.size(); i++) begin
      ea   = addr + 32'(4 * i);
      ecti = (i == n - 1) ? 3'b111 : 3'b010;
      checks++;
      if (beat_q[i].addr !== ea || beat_q[i].cti !== ecti || beat_q[i].we !== we ||
          (we && beat_q[i].data !== wbuf[i])) begin
        errors++;
        $display("FAIL beat%0d addr=%h cti=%b we=%b data=%h required %h %b %b %h", i,
                 beat_q[i].addr, beat_q[i].cti, beat_q[i].we, beat_q[i].data, ea, ecti, we,
                 we ? wbuf[i] : beat_q[i].data);
      end
    end
    if (we) begin
      for (int i = 0; i < n; i++) begin
        ea = addr + 32'(4 * i);
        rmem[ea[11:2]] = wbuf[i];
      end
    end else begin
      checks++;
      if (rd_q.size() != n || lat_bad != 0) begin
        errors++;
        $display("FAIL rd_stream beats=%0d latency_errs=%0d required %0d 0", rd_q.size(), lat_bad, n);
      end
      for (int i = 0; i < n && i < rd_q.size(); i++) begin
        ea = addr + 32'(4 * i);
        checks++;
        if (rd_q[i] !== rmem[ea[11:2]]) begin
          errors++;
          $display("FAIL rd_data%0d got=%h required %h", i, rd_q[i], rmem[ea[11:2]]);
        end
      end
    end
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (cmd_ready !== 1'b0 || wb_cyc_i !== 1'b0 || wb_stb_i !== 1'b0 || wb_we_i !== 1'b0 ||
        wb_addr_i !== 32'h0 || wb_sel_i !== 4'h0 || wb_cti_i !== 3'b000 || wb_dat_i !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus rdy=%b cyc=%b stb=%b we=%b addr=%h sel=%h cti=%b dat=%h required all 0",
               cmd_ready, wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_cti_i, wb_dat_i);
    end
    checks++;
    if (done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0 || timeout !== 1'b0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_stream done=%b rd_valid=%b rd_data=%h timeout=%b wr_ready=%b required all 0",
               done, rd_valid, rd_data, timeout, wr_ready);
    end
    @(posedge sys_clk); #1;
    RESETN = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge cmd_ready=%b required 0", cmd_ready);
    end
    @(negedge sys_clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_write_burst();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    run_burst(1'b1, 32'h100, 8'd4, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_read_burst();
    run_burst(1'b0, 32'h100, 8'd4, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_single_beat();
    wbuf[0] = $urandom;
    run_burst(1'b1, 32'h40, 8'd1, -1, 0, 1'b0, 1'b0);
    run_burst(1'b0, 32'h40, 8'd1, -1, 0, 1'b0, 1'b0);
    wbuf[0] = $urandom;
    run_burst(1'b1, 32'h40, 8'd0, -1, 0, 1'b0, 1'b0);
    run_burst(1'b0, 32'h40, 8'd0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_write_gap();
    for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
    run_burst(1'b1, 32'h200, 8'd8, 1, 3, 1'b1, 1'b0);
    run_burst(1'b0, 32'h200, 8'd8, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_addr_wrap();
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    run_burst(1'b1, 32'hFFFF_FFF8, 8'd4, -1, 0, 1'b0, 1'b0);
    run_burst(1'b0, 32'hFFFF_FFF8, 8'd4, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    bit got;
    @(posedge sys_clk); #1;
    beat_q.delete(); done_cnt = 0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h300; cmd_len = 8'd8;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge sys_clk);
      got = (cmd_ready === 1'b1);
    end
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge sys_clk);
      got = (beat_q.size() >= 2);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL mid_burst_wait beats=%0d required 2", beat_q.size());
    end
    @(posedge sys_clk); #1;
    RESETN = 1'b0;
    @(posedge sys_clk); #1;
    RESETN = 1'b1;
    checks++;
    if (wb_cyc_i !== 1'b0 || wb_stb_i !== 1'b0 || wb_addr_i !== 32'h0 || cmd_ready !== 1'b0 ||
        rd_valid !== 1'b0 || wb_cti_i !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset cyc=%b stb=%b addr=%h rdy=%b rd_valid=%b cti=%b required 0 0 0 0 0 0",
               wb_cyc_i, wb_stb_i, wb_addr_i, cmd_ready, rd_valid, wb_cti_i);
    end
    repeat (10) @(negedge sys_clk);
    checks++;
    if (done_cnt != 0 || cmd_ready !== 1'b1 || wb_cyc_i !== 1'b0) begin
      errors++;
      $display("FAIL post_reset done_pulses=%0d rdy=%b cyc=%b required 0 1 0", done_cnt, cmd_ready, wb_cyc_i);
    end
    run_burst(1'b0, 32'h100, 8'd4, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic        we;
    logic [31:0] addr;
    logic [7:0]  len;
    int          n, gap;
    for (int it = 0; it < 14; it++) begin
      we   = 1'($urandom_range(0, 1));
      addr = (32'($urandom_range(0, 900)) << 2) | ($urandom & 32'hFFFF_F000);
      len  = 8'($urandom_range(0, 9));
      n    = (len == 8'd0) ? 1 : int'(len);
      for (int i = 0; i < n; i++) wbuf[i] = $urandom;
      gap  = (we && n > 2) ? $urandom_range(0, n - 2) : -1;
      run_burst(we, addr, len, gap, $urandom_range(1, 3), 1'b0, 1'b0);
    end
  endtask

`ifdef WB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    bit got;
    int stb_cyc;
    noack = 1'b1;
    @(posedge sys_clk); #1;
    done_cnt = 0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h100; cmd_len = 8'd4;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge sys_clk);
      got = (cmd_ready === 1'b1);
    end
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    stb_cyc = 0;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge sys_clk);
      if (wb_cyc_i === 1'b1) stb_cyc += int'(wb_stb_i);
      else got = 1;
    end
    checks++;
    if (!got || stb_cyc != 16 || timeout !== 1'b1 || wb_stb_i !== 1'b0) begin
      errors++;
      $display("FAIL timeout_expiry dropped=%0d stb_cycles=%0d timeout=%b stb=%b required 1 16 1 0",
               got, stb_cyc, timeout, wb_stb_i);
    end
    repeat (4) @(negedge sys_clk);
    checks++;
    if (done_cnt != 0 || timeout !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky done_pulses=%0d timeout=%b rdy=%b required 0 1 1",
               done_cnt, timeout, cmd_ready);
    end
    noack = 1'b0;
    timeout_exp = 1'b1;
    run_burst(1'b0, 32'h100, 8'd2, -1, 0, 1'b0, 1'b0);
    @(posedge sys_clk); #1;
    RESETN = 1'b0;
    @(posedge sys_clk); #1;
    RESETN = 1'b1;
    timeout_exp = 1'b0;
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear timeout=%b required 0", timeout);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) begin
      smem[i] = $urandom;
      rmem[i] = smem[i];
    end
    test_reset();
    test_write_burst();
    test_read_burst();
    test_single_beat();
    test_write_gap();
    test_reset_mid_burst();
    test_addr_wrap();
    test_random();
`ifdef WB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_time_limit elapsed=%0t required completion", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
